// File: rtl/apb_reg_bank.sv
// APB slave register bank: NUM_REGS read/write registers plus a read-only transfer counter (CNTR).
// Configurable wait states before PREADY; PSLVERR is returned for unmapped or misaligned addresses.
module apb_reg_bank #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    output logic              pready,
    output logic              pslverr
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic                r_err;
    logic                r_write;
    logic [2:0]          r_wait;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_cntr;

    logic [ADDR_W-1:0]   w_offset;
    logic [ADDR_W-3:0]   w_word;
    logic                w_dec_err;
    logic                w_setup_req;
    logic                w_access;
    logic                w_done;
    logic                w_commit;
    logic                w_load;
    logic                w_is_cntr;
    logic [NUM_REGS-1:0] w_reg_we;
    logic [DATA_W-1:0]   w_rd_reg;

    assign w_offset    = addr - BASE_ADDR;
    assign w_word      = w_offset[ADDR_W-1:2];
    assign w_dec_err   = (addr < BASE_ADDR) || ((addr[1:0] | w_offset[1:0]) != 2'b00)
                         || (w_word > (ADDR_W-2)'(NUM_REGS));
    assign w_setup_req = psel && !penable;

    // The first access-phase cycle is spent in SETUP so that a zero-wait
    // transfer completes in the second bus cycle.
    assign w_access  = psel && ((r_state == ST_ACCESS) || ((r_state == ST_SETUP) && penable));
    assign w_done    = w_access && (r_wait == 3'd0);
    assign w_commit  = w_done && !r_err;
    assign w_load    = w_setup_req && ((r_state == ST_IDLE) || w_done);
    assign w_is_cntr = (r_idx == IDX_W'(NUM_REGS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup_req) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (w_done) begin
                    w_state_next = w_setup_req ? ST_SETUP : ST_IDLE;
                end else if (!w_access) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ACCESS;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pready  = w_done;
        pslverr = w_done && r_err;
        prdata  = '0;
        if (w_commit && !r_write) begin
            prdata = w_is_cntr ? r_cntr : w_rd_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_wait  <= 3'd0;
        end else if (w_load) begin
            r_idx   <= w_word[IDX_W-1:0];
            r_err   <= w_dec_err;
            r_write <= pwrite;
            r_wait  <= 3'(WAIT_STATES);
        end else if (w_access && (r_wait != 3'd0)) begin
            r_wait  <= r_wait - 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign w_reg_we[gi] = w_commit && r_write && (r_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_reg_we[i]) begin
                    r_regs[i] <= pwdata;
                end
            end
        end
    end

    always_comb begin
        w_rd_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_rd_reg = r_regs[i];
            end
        end
    end

    // A completed write to CNTR clears it and suppresses that transfer's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cntr <= '0;
        end else if (w_commit) begin
            if (r_write && w_is_cntr) begin
                r_cntr <= '0;
            end else begin
                r_cntr <= r_cntr + 1'b1;
            end
        end
    end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
Parametrised APB slave register bank. It generalises the fixed-width, zero-wait APB peripheral into a block with configurable data width, register count, base address and wait states. It adds PREADY/PSLVERR signalling and a read-only transfer counter. It sits behind the APB bridge and can be instantiated once per peripheral slot.

Parameters:
DATA_W, 32, data bus width in bits (8..32).
ADDR_W, 32, address bus width in bits.
NUM_REGS, 8, number of general read/write registers (1..64).
BASE_ADDR, 32'h0000_0000, byte address of register 0.
WAIT_STATES, 0, wait cycles inserted in each access phase before PREADY (0..7).

Ports:
clk  in  1  APB clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
addr  in  ADDR_W  APB byte address.
pwdata  in  DATA_W  write data.
prdata  out  DATA_W  read data; valid only in the completion cycle of a read, 0 otherwise.
pwrite  in  1  1 = write, 0 = read.
psel  in  1  slave select.
penable  in  1  access-phase strobe.
pready  out  1  transfer-complete strobe.
pslverr  out  1  error response; valid only when pready = 1.

Behaviour:
- Reset: async assert. All registers and CNTR go to 0, FSM goes to IDLE, wait counter goes to 0. prdata, pready and pslverr are all 0 while reset is high and in the first cycle after release.
- Register map: word index idx = (addr - BASE_ADDR) >> 2.
  - idx 0..NUM_REGS-1: REG[idx], read/write.
  - idx NUM_REGS: CNTR, read-only. A write of any value clears it.
  - Any other index, or addr[1:0] != 0, or addr < BASE_ADDR: error.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0. Decode result and pwrite are latched and the wait counter is loaded with WAIT_STATES.
  - SETUP -> ACCESS on the next edge if psel=1 and penable=1. Otherwise SETUP -> IDLE, with no effect.
  - In ACCESS, the wait counter decrements each cycle while nonzero.
  - pready = (state==ACCESS) and (wait counter == 0). This is combinational, so WAIT_STATES=0 gives pready in the first access cycle.
  - ACCESS -> IDLE on the completion edge (pready=1). If the next transfer starts back-to-back, ACCESS -> SETUP instead, when psel=1 and penable=0 at that edge.
  - If psel drops during ACCESS before pready: abort to IDLE. No write, no count, no error.
- Completion cycle (pready=1):
  - Write, no error: REG[idx] <= pwdata at the edge. A write to CNTR sets CNTR to 0.
  - Read, no error: prdata = REG[idx] or CNTR, combinational from the latched index.
  - Error: pslverr=1, prdata=0, and no state is modified.
- CNTR increments by 1 at every completed non-error transfer (read or write) and wraps from 2^DATA_W-1 to 0.
  - A completed write to CNTR: the clear wins, so CNTR = 0 afterwards and no increment is applied.
  - A completed read of CNTR returns the pre-increment value.
- Latency: a transfer completes in 2 + WAIT_STATES cycles, counted from the setup cycle.
- Width rules: pwdata is stored in full, with no byte strobes. addr bits above those needed for decode still take part in the range check.
- Reset asserted mid-transfer: the transfer is abandoned and no write takes effect. The bus master sees pready=0.

Test Plan:
1. Reset, NUM_REGS=8, WAIT_STATES=0. Write 0xDEADBEEF to addr 0x04, then read 0x04 -> pready on the second cycle of each transfer, prdata=0xDEADBEEF, pslverr=0, CNTR reads 2 on a third read at 0x20 (the CNTR read itself returns the pre-increment value).
2. WAIT_STATES=3. Read of addr 0x00 after a write of 0x12345678 -> pready low for 3 access cycles, high on the 4th, prdata=0x12345678 only in that cycle.
3. Write to addr 0x24 (idx 9, out of range) and to misaligned 0x06 -> pslverr=1 with pready. All REGs are unchanged and CNTR does not increment.
4. Run 5 good transfers, then write 0xFFFF to CNTR (0x20), then read 0x20 -> CNTR reads 0, proving clear beats increment. A following read returns 1.
5. WAIT_STATES=2. Write 0xA5 to 0x08, but drop psel after 1 access cycle -> no pready, REG[2] is unchanged, CNTR is unchanged, FSM is back in IDLE and accepts the next transfer.
6. Assert reset during the ACCESS of a write of 0x55 to 0x00 -> pready=0, REG[0]=0 after reset. Back-to-back reads with no IDLE between them both complete correctly.
